// File: rtl/sensor_frontend.sv
// Sensor front end: synchronises and debounces the four binary sensor pins, and
// range-checks, averages and watches for staleness on the temperature ADC samples.
module sensor_frontend #(
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned TEMP_RST     = 25,
    parameter int unsigned TEMP_MAX     = 100,
    parameter int unsigned STALE_CYCLES = 1000
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       raw_fd,
    input  logic       raw_rd,
    input  logic       raw_w,
    input  logic       raw_fa,
    input  logic [6:0] adc_data,
    input  logic       adc_valid,
    output logic       SFD,
    output logic       SRD,
    output logic       SW,
    output logic       SFA,
    output logic [6:0] ST,
    output logic       temp_fault,
    output logic       temp_stale,
    output logic       sensor_event
);

    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 8;
    localparam int unsigned TW   = 7;
    localparam int unsigned SUMW = 9;
    localparam int unsigned STW  = 16;
    localparam int unsigned SNW  = NCH + TW;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] deb;
    logic [CW-1:0]  deb_cnt [NCH];

    assign raw = {raw_fd, raw_rd, raw_w, raw_fa};

    // Two-flop synchroniser plus per-channel stability counter
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < NCH; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign SFD = deb[3];
    assign SRD = deb[2];
    assign SW  = deb[1];
    assign SFA = deb[0];

    // Temperature path; the fourth averaging slot is always the incoming sample
    logic            accept_c;
    logic            reject_c;
    logic [TW-1:0]   hist [3];
    logic [2:0]      scount;
    logic [SUMW-1:0] sum_c;
    logic [STW-1:0]  stale_cnt;
    logic [STW-1:0]  stale_nxt_c;

    assign accept_c = adc_valid && (adc_data <= TW'(TEMP_MAX));
    assign reject_c = adc_valid && !accept_c;
    assign sum_c    = SUMW'(adc_data) + SUMW'(hist[0]) + SUMW'(hist[1]) + SUMW'(hist[2]);

    always_comb begin
        stale_nxt_c = stale_cnt;
        if (accept_c)
            stale_nxt_c = '0;
        else if (stale_cnt != STW'(STALE_CYCLES))
            stale_nxt_c = stale_cnt + STW'(1);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 3; i++) hist[i] <= '0;
            scount     <= '0;
            ST         <= TW'(TEMP_RST);
            temp_fault <= 1'b0;
            stale_cnt  <= '0;
            temp_stale <= 1'b0;
        end else begin
            temp_fault <= reject_c;
            stale_cnt  <= stale_nxt_c;
            temp_stale <= (stale_nxt_c == STW'(STALE_CYCLES));
            if (accept_c) begin
                hist[0] <= adc_data;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                if (scount != 3'd4)
                    scount <= scount + 3'd1;
                if (scount >= 3'd3)
                    ST <= TW'(sum_c >> 2);
            end
        end
    end

    // Change detector over every conditioned output
    logic [SNW-1:0] snap_c;
    logic [SNW-1:0] snap_q;

    assign snap_c = {SFD, SRD, SW, SFA, ST};

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            snap_q       <= {4'b0000, TW'(TEMP_RST)};
            sensor_event <= 1'b0;
        end else begin
            snap_q       <= snap_c;
            sensor_event <= (snap_c != snap_q);
        end
    end

endmodule
